serial_paralelo: RTL and testbench
==================================

Name: serial_paralelo

Overview:
- Receive-side deserializer; sits directly downstream of the parallel-to-serial transmitter in the phy.
- Takes the 1-bit serial line at clk_32f rate, MSB first, and finds byte alignment using the idle comma character.
- After lock, it recovers 8-bit data bytes and separates data from idle.
- Outputs are held for a full byte period so a clk_4f-domain consumer can sample them.

Parameters:
COM_CHAR, 8'hBC, idle/comma byte the transmitter sends whenever it has no valid data (bit order on the line: 1,0,1,1,1,1,0,0).
COM_LOCK_COUNT, 4, consecutive aligned COM_CHAR bytes needed to declare lock (legal range 2..15).

Ports:
clk_32f  in  1  bit-rate clock; single clock, all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
in_serial  in  1  serial data, MSB of each byte first.
out_parallel  out  8  recovered data byte.
valid_out  out  1  out_parallel holds a data (non-COM) byte; held for the whole byte period.
strobe_out  out  1  one-cycle pulse, on the first cycle of each new valid byte.
active  out  1  receiver locked (state LOCKED).

Behaviour:
- Reset values: reset=1 at a clk_32f edge sets out_parallel=0, valid_out=0, strobe_out=0, active=0, shift_reg=0, bit_cnt=0, com_cnt=0, state=SEARCH. This applies from any state, mid-byte included, and takes effect after that edge.
- shift_reg[7:0] shifts every cycle: shift_reg <= {shift_reg[6:0], in_serial}.
- window = {shift_reg[6:0], in_serial}; this is the byte completed by the current bit.
- bit_cnt: 3-bit, increments every cycle, wraps from 7 to 0.
- Boundary cycle:
  - In SEARCH: any cycle where window==COM_CHAR.
  - In VERIFY and LOCKED: any cycle where bit_cnt==7.
- States:
  - SEARCH:
    - window==COM_CHAR -> go to VERIFY; bit_cnt<=0; com_cnt<=1.
    - Otherwise stay in SEARCH. Outputs stay 0.
  - VERIFY, at each boundary:
    - window==COM_CHAR: com_cnt<=com_cnt+1. If com_cnt+1==COM_LOCK_COUNT, go to LOCKED.
    - window!=COM_CHAR: go to SEARCH; com_cnt<=0.
    - Outputs stay 0.
  - LOCKED (active=1):
    - At a boundary with window!=COM_CHAR: out_parallel<=window, valid_out<=1, strobe_out<=1 for one cycle.
    - At a boundary with window==COM_CHAR: valid_out<=0; out_parallel holds its last value.
    - Between boundaries: all outputs hold, and strobe_out=0.
    - LOCKED is left only via reset.
- Latency: the last bit of a byte is sampled at edge k; out_parallel, valid_out and strobe_out change at that same edge k and are visible in cycle k+1. Latency is 1 clk_32f cycle from last bit to output.
- Data byte equal to COM_CHAR while LOCKED: treated as idle (valid_out=0). This is a protocol restriction shared with the transmitter.
- Misaligned COM_CHAR look-alikes while in SEARCH: may start VERIFY. A subsequent non-COM boundary returns the block to SEARCH, so no false lock occurs without COM_LOCK_COUNT consecutive aligned commas.
- Simultaneous events: reset has priority over every state transition and output update.
- Widths: com_cnt is 4 bits with no overflow in range. All compares are exact 8-bit.

Test Plan:
- Aligned idle stream: reset released, then COM_CHAR sent repeatedly MSB first starting at cycle 0.
  - VERIFY entered at edge 7; commas at edges 15, 23, 31; LOCKED and active=1 from cycle 32.
  - valid_out stays 0 throughout.
- Misaligned start: 3 bits 0,1,0, then COM_CHAR x4.
  - Lock occurs at edge 34 (window 10..34); active=1 from cycle 35, byte phase aligned to the comma.
- Data after lock: locked as in scenario 1, then 0xA5, 0x3C, then COM_CHAR.
  - out_parallel=0xA5 with valid_out=1 for 8 cycles, then 0x3C for 8 cycles.
  - strobe_out pulses once per byte.
  - Then valid_out=0 and out_parallel holds 0x3C.
- Broken verify: COM_CHAR, COM_CHAR, 0xBD, COM_CHAR x4.
  - Returns to SEARCH at the 0xBD boundary; active=0 until the 4th following comma.
  - No valid_out assertion.
- Reset mid-operation: reset=1 for 1 cycle at bit 4 of a data byte while LOCKED.
  - Next cycle: all outputs 0, state SEARCH.
  - Relock requires 4 fresh commas.
- COM_CHAR as data while LOCKED: 0x11, 0xBC, 0x22.
  - valid_out is 1, then 0 (out_parallel stays 0x11), then 1 with 0x22.

Source files
------------

// File: rtl/serial_paralelo.sv
// Receive-side deserializer: finds byte alignment from the idle comma on a
// 1-bit MSB-first line and recovers data bytes held for a full byte period.
module serial_paralelo #(
    parameter logic [7:0]  COM_CHAR       = 8'hBC,
    parameter int unsigned COM_LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       in_serial,
    output logic [7:0] out_parallel,
    output logic       valid_out,
    output logic       strobe_out,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t     state;
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
    logic [7:0] window;
    logic       is_com;
    logic       boundary;

    // Only seven bits of history are kept; the eighth is the live input bit,
    // so window is the byte completed by the bit sampled on this edge.
    assign window   = {shift_reg, in_serial};
    assign is_com   = (window == COM_CHAR);
    assign boundary = (bit_cnt == 3'd7);

    // NOTE: every register here uses non-blocking assignment so that all
    // reads in this block see pre-edge values, matching the flop behaviour.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state        <= SEARCH;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            com_cnt      <= '0;
            out_parallel <= '0;
            valid_out    <= 1'b0;
            strobe_out   <= 1'b0;
            active       <= 1'b0;
        end else begin
            shift_reg  <= window[6:0];
            bit_cnt    <= bit_cnt + 3'd1;
            strobe_out <= 1'b0;

            case (state)
                SEARCH: begin
                    // Any comma match, aligned or not, starts a candidate phase.
                    if (is_com) begin
                        state   <= VERIFY;
                        bit_cnt <= '0;
                        com_cnt <= 4'd1;
                    end
                end

                VERIFY: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt <= com_cnt + 4'd1;
                            if (com_cnt + 4'd1 == 4'(COM_LOCK_COUNT)) begin
                                state  <= LOCKED;
                                active <= 1'b1;
                            end
                        end else begin
                            state   <= SEARCH;
                            com_cnt <= '0;
                        end
                    end
                end

                LOCKED: begin
                    // A comma inside the data stream is idle; the last byte stays visible.
                    if (boundary) begin
                        if (is_com) begin
                            valid_out <= 1'b0;
                        end else begin
                            out_parallel <= window;
                            valid_out    <= 1'b1;
                            strobe_out   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= SEARCH;
                    com_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: stimulus pushes expected bytes into a
// queue, a monitor pops and compares them on every strobe_out pulse.
module tb_serial_paralelo;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset = 1'b1;
    logic       in_serial = 1'b0;
    logic [7:0] out_parallel;
    logic       valid_out;
    logic       strobe_out;
    logic       active;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];

    always #5 clk_32f = ~clk_32f;

    serial_paralelo #(
        .COM_CHAR      (COM),
        .COM_LOCK_COUNT(4)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .in_serial   (in_serial),
        .out_parallel(out_parallel),
        .valid_out   (valid_out),
        .strobe_out  (strobe_out),
        .active      (active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Drive one bit, let the edge consume it, then sit 1 time unit past the edge.
    task automatic tick(input logic b);
        in_serial = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    // First seven bits with the outputs checked as held, then the final bit.
    task automatic send_byte_hold(input logic [7:0] b, input logic exp_valid,
                                  input logic [7:0] exp_out, input string name);
        for (int i = 7; i >= 1; i--) begin
            tick(b[i]);
            check(name, 32'({valid_out, strobe_out, out_parallel}),
                  32'({exp_valid, 1'b0, exp_out}));
        end
        tick(b[0]);
    endtask

    task automatic do_reset(input string name);
        reset     = 1'b1;
        in_serial = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        check(name, 32'({active, valid_out, strobe_out, out_parallel}), 32'd0);
        reset = 1'b0;
    endtask

    // Four aligned commas from the current phase; active must rise on the last bit.
    task automatic lock_aligned(input string name);
        repeat (3) send_byte_hold(COM, 1'b0, 8'h00, {name, "_idle"});
        for (int i = 7; i >= 1; i--) tick(COM[i]);
        check({name, "_pre"}, 32'(active), 32'd0);
        tick(COM[0]);
        check({name, "_lock"}, 32'(active), 32'd1);
    endtask

    // Monitor: every strobe must match the oldest expected byte.
    always @(posedge clk_32f) begin
        #1;
        if (strobe_out) begin
            if (exp_q.size() == 0) check("unexpected_strobe", 32'(strobe_out), 32'd0);
            else check("strobe_byte", 32'({valid_out, out_parallel}),
                       32'({1'b1, exp_q.pop_front()}));
        end
    end

    initial begin
        // Aligned idle stream: VERIFY at edge 7, lock at edge 31.
        do_reset("reset_state");
        send_byte(COM);
        check("verify_not_active", 32'(active), 32'd0);
        send_byte_hold(COM, 1'b0, 8'h00, "aligned_idle");
        send_byte(COM);
        for (int i = 7; i >= 1; i--) tick(COM[i]);
        check("aligned_pre_lock", 32'(active), 32'd0);
        tick(COM[0]);
        check("aligned_lock", 32'({active, valid_out}), 32'b10);

        // Misaligned start: 0,1,0 then four commas, lock at edge 34.
        do_reset("reset_misaligned");
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        lock_aligned("misaligned");
        exp_q.push_back(8'h5A);
        send_byte(8'h5A);
        check("misaligned_data", 32'({valid_out, strobe_out, out_parallel}), 32'({2'b11, 8'h5A}));

        // Data after lock, then idle.
        do_reset("reset_data");
        lock_aligned("data");
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        check("data_a5", 32'({valid_out, strobe_out, out_parallel}), 32'({2'b11, 8'hA5}));
        exp_q.push_back(8'h3C);
        send_byte_hold(8'h3C, 1'b1, 8'hA5, "hold_a5");
        check("data_3c", 32'({valid_out, strobe_out, out_parallel}), 32'({2'b11, 8'h3C}));
        send_byte_hold(COM, 1'b1, 8'h3C, "hold_3c");
        check("idle_after_data", 32'({valid_out, strobe_out, out_parallel}), 32'({2'b00, 8'h3C}));

        // Broken verify: the 0xBD boundary sends the block back to SEARCH.
        do_reset("reset_broken");
        send_byte(COM);
        send_byte(COM);
        send_byte(8'hBD);
        check("broken_not_active", 32'(active), 32'd0);
        lock_aligned("broken_relock");
        check("broken_no_valid", 32'(valid_out), 32'd0);

        // Reset at bit 4 of a data byte while locked.
        do_reset("reset_midop");
        lock_aligned("midop");
        exp_q.push_back(8'h77);
        send_byte(8'h77);
        for (int i = 7; i >= 4; i--) tick(8'h5A >> i);
        check("midop_hold", 32'({active, valid_out, out_parallel}), 32'({2'b11, 8'h77}));
        reset = 1'b1;
        tick(1'b1);
        check("midop_reset", 32'({active, valid_out, strobe_out, out_parallel}), 32'd0);
        reset = 1'b0;
        lock_aligned("midop_relock");
        exp_q.push_back(8'hC3);
        send_byte(8'hC3);
        check("midop_data", 32'({valid_out, out_parallel}), 32'({1'b1, 8'hC3}));

        // Comma inside the data stream reads as idle.
        do_reset("reset_comdata");
        lock_aligned("comdata");
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        check("comdata_11", 32'({valid_out, strobe_out, out_parallel}), 32'({2'b11, 8'h11}));
        send_byte_hold(COM, 1'b1, 8'h11, "comdata_hold_11");
        check("comdata_bc", 32'({valid_out, strobe_out, out_parallel}), 32'({2'b00, 8'h11}));
        exp_q.push_back(8'h22);
        send_byte_hold(8'h22, 1'b0, 8'h11, "comdata_idle");
        check("comdata_22", 32'({valid_out, strobe_out, out_parallel}), 32'({2'b11, 8'h22}));

        repeat (2) @(posedge clk_32f);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
